// File: rtl/instr_prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue_if
// Instruction-memory request/response bus between the prefetch queue (master)
// and the instruction memory (slave).
//
// Signals:
//   imem_req    master->slave  request valid
//   imem_addr   master->slave  16-bit word address of the request
//   imem_gnt    slave->master  request accepted this cycle
//   imem_rvalid slave->master  response valid (responses return in request order)
//   imem_rdata  slave->master  16-bit instruction word
//
// Handshake: a request transfers on a rising edge where imem_req && imem_gnt.
// imem_addr is stable while imem_req is high. imem_gnt is ignored when imem_req
// is low. Responses have no back-pressure: each imem_rvalid cycle carries one
// response, in the same order the requests were granted.
// -----------------------------------------------------------------------------
interface instr_prefetch_queue_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
// Instruction fetch front end feeding the IF/ID stage. Issues sequential word
// fetches to instruction memory, queues the in-order responses as {PC, inst}
// pairs in a DEPTH-entry FIFO and presents the head to decode. A redirect
// flushes the queue and discards responses still in flight.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, 2..16)
//   RESET_PC  first fetch address after reset
//   MAX_OUTST maximum outstanding imem requests (1..DEPTH)
//
// Ports:
//   CLK, RST_N   clock (rising edge), asynchronous active-low reset
//   stall        decode not accepting this cycle
//   redirect     kill/redirect, redirect_pc is the new fetch target
//   imem         instruction-memory bus (master modport)
//   inst_valid   head entry valid toward IF/ID
//   inst_out     head instruction, 16'h0000 when not valid
//   pc_out       PC of head instruction, 16'h0000 when not valid
//   dbg_state_o  current FSM state (0 IDLE, 1 RUN, 2 FLUSH)
//
// Optional feature macro: PREFETCH_BYPASS_EN. When defined, a response that
// arrives while the FIFO is empty and decode is accepting is presented on the
// outputs in the same cycle instead of being written to the FIFO.
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          MAX_OUTST = 2
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          stall,
  input  logic                          redirect,
  input  logic [15:0]                   redirect_pc,
  instr_prefetch_queue_if.master        imem,
  output logic                          inst_valid,
  output logic [15:0]                   inst_out,
  output logic [15:0]                   pc_out,
  output logic [1:0]                    dbg_state_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   tail_pc_q, tail_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_q [DEPTH];

  logic          running;
  logic          resp;
  logic          grant;
  logic          fifo_valid;
  logic          pop;
  logic          push;
  logic          bypass;
  logic [CW:0]   credit_sum;

  assign running    = (state_q == ST_RUN);
  assign resp       = imem.imem_rvalid;
  assign credit_sum = {1'b0, count_q} + {1'b0, outst_q};

  // Credit rule: every outstanding request already owns a FIFO slot, so the
  // queue can never overflow no matter how long decode stalls.
  assign imem.imem_req  = running && !redirect && (outst_q < MAXO_C) &&
                          (credit_sum < {1'b0, DEPTH_C});
  assign imem.imem_addr = fetch_pc_q;
  assign grant          = imem.imem_req && imem.imem_gnt;

  // Redirect kills the head in the same cycle so decode never consumes a
  // wrong-path instruction.
  assign fifo_valid = running && !redirect && (count_q != '0);

`ifdef PREFETCH_BYPASS_EN
  assign bypass = running && (count_q == '0) && resp && !stall && !redirect;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = fifo_valid && !stall;
  assign push = running && resp && !redirect && !bypass;

  assign inst_valid  = fifo_valid || bypass;
  assign dbg_state_o = state_q;

  always_comb begin
    inst_out = 16'h0000;
    pc_out   = 16'h0000;
    if (fifo_valid) begin
      {pc_out, inst_out} = mem_q[rd_ptr_q];
    end else if (bypass) begin
      pc_out   = tail_pc_q;
      inst_out = imem.imem_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    tail_pc_d  = tail_pc_q;
    count_d    = count_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    // The outstanding count follows the bus in every state; responses that
    // are dropped still retire a request.
    outst_d    = outst_q + CW'(grant) - CW'(resp);

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      tail_pc_d  = redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Everything still in flight after this cycle belongs to the old path.
      drop_d     = outst_d;
      state_d    = (outst_d != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (grant) fetch_pc_d = fetch_pc_q + 16'd1;
          if (push || bypass) tail_pc_d = tail_pc_q + 16'd1;
          if (push) wr_ptr_d = wr_ptr_q + AW'(1);
          if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
          count_d = count_q + CW'(push) - CW'(pop);
        end
        ST_FLUSH: begin
          if (resp) drop_d = drop_q - CW'(1);
          if (drop_d == '0) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      tail_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tail_pc_q  <= tail_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {tail_pc_q, imem.imem_rdata};
  end

  // A push into a full queue without a pop would overwrite the head entry.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
    !(push && !pop && (count_q == DEPTH_C)));

  // Memory must not answer a request that was never granted.
  a_no_spurious_resp: assert property (@(posedge CLK) disable iff (!RST_N)
    !(resp && (outst_q == '0)));

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_queue
// Drives instr_prefetch_queue with an in-order, variable-latency memory model
// and checks the decode-side stream against a queue-based reference.
// Memory content is a fixed function of the address, so every delivered
// instruction must carry the PC it was fetched from.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_queue;
  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [15:0] RESET_PC  = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic [15:0] inst_out;
  logic [15:0] pc_out;
  logic [1:0]  dbg_state;

  instr_prefetch_queue_if imem_if ();

  instr_prefetch_queue #(
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_if),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_q[$];     // {pc, inst} entries the queue must hold
  logic [15:0] mem_q[$];     // addresses granted, awaiting response
  int          mem_t[$];     // earliest cycle each response may return
  logic [15:0] next_fetch_m;
  int          drop_m;
  bit          idle_m;
  int          cyc;
  int          lat_lo, lat_hi;
  int          n_tests, n_fail;
  bit          popped;
  logic [15:0] popped_pc;
  bit          granted;
  logic [15:0] granted_addr;

  function automatic logic [15:0] inst_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mem_q.delete();
    mem_t.delete();
    next_fetch_m = RESET_PC;
    drop_m       = 0;
    idle_m       = 1'b1;
  endtask

  task automatic drive_idle();
    stall               = 1'b0;
    redirect            = 1'b0;
    redirect_pc         = 16'h0000;
    imem_if.imem_gnt    = 1'b0;
    imem_if.imem_rvalid = 1'b0;
    imem_if.imem_rdata  = 16'h0000;
  endtask

  // ---------------- driver + scoreboard, one clock cycle ----------------
  task automatic step(input bit st, input bit rd, input logic [15:0] rpc,
                      input bit g, input bit rok);
    bit          resp;
    bit          running;
    bit          exp_req;
    bit          byp;
    bit          exp_valid;
    logic [15:0] raddr;
    logic [15:0] exp_pc;
    logic [15:0] exp_inst;
    @(negedge clk);
    resp = 1'b0;
    if (rok && mem_q.size() > 0) begin
      if (cyc >= mem_t[0]) resp = 1'b1;
    end
    raddr = resp ? mem_q[0] : 16'h0000;
    stall               = st;
    redirect            = rd;
    redirect_pc         = rpc;
    imem_if.imem_gnt    = g;
    imem_if.imem_rvalid = resp;
    imem_if.imem_rdata  = resp ? inst_of(raddr) : 16'($urandom);
    #1;
    running = !idle_m && (drop_m == 0);
    exp_req = running && !rd && (mem_q.size() < MAX_OUTST) &&
              ((exp_q.size() + mem_q.size()) < DEPTH);
    byp = 1'b0;
`ifdef PREFETCH_BYPASS_EN
    byp = running && !rd && resp && !st && (exp_q.size() == 0);
`endif
    exp_valid = 1'b0;
    exp_pc    = 16'h0000;
    exp_inst  = 16'h0000;
    if (!rd && exp_q.size() > 0) begin
      exp_valid = 1'b1;
      {exp_pc, exp_inst} = exp_q[0];
    end else if (byp) begin
      exp_valid = 1'b1;
      exp_pc    = raddr;
      exp_inst  = inst_of(raddr);
    end

    n_tests++;
    if (imem_if.imem_req !== exp_req) begin
      n_fail++;
      $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_if.imem_req, exp_req);
    end
    if (exp_req) begin
      n_tests++;
      if (imem_if.imem_addr !== next_fetch_m) begin
        n_fail++;
        $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_if.imem_addr, next_fetch_m);
      end
    end
    n_tests++;
    if (inst_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_valid);
    end
    n_tests++;
    if (pc_out !== exp_pc) begin
      n_fail++;
      $display("FAIL pc_out cyc=%0d got=%h exp=%h", cyc, pc_out, exp_pc);
    end
    n_tests++;
    if (inst_out !== exp_inst) begin
      n_fail++;
      $display("FAIL inst_out cyc=%0d got=%h exp=%h", cyc, inst_out, exp_inst);
    end

    popped  = 1'b0;
    granted = 1'b0;
    if (rd) begin
      exp_q.delete();
      if (resp) begin
        void'(mem_q.pop_front());
        void'(mem_t.pop_front());
      end
      drop_m       = mem_q.size();
      next_fetch_m = rpc;
    end else begin
      if (byp) begin
        popped    = 1'b1;
        popped_pc = raddr;
      end else if (exp_q.size() > 0 && !st) begin
        popped    = 1'b1;
        popped_pc = exp_q[0][31:16];
        void'(exp_q.pop_front());
      end
      if (resp) begin
        void'(mem_q.pop_front());
        void'(mem_t.pop_front());
        if (drop_m > 0) drop_m--;
        else if (!byp) exp_q.push_back({raddr, inst_of(raddr)});
      end
      if (imem_if.imem_req && g) begin
        granted      = 1'b1;
        granted_addr = imem_if.imem_addr;
        mem_q.push_back(imem_if.imem_addr);
        mem_t.push_back(cyc + $urandom_range(lat_hi, lat_lo));
        next_fetch_m = next_fetch_m + 16'd1;
      end
    end
    idle_m = 1'b0;
    cyc++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (imem_if.imem_req !== 1'b0 || imem_if.imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_req got req=%b addr=%h exp req=0 addr=%h",
               imem_if.imem_req, imem_if.imem_addr, RESET_PC);
    end
    n_tests++;
    if (inst_valid !== 1'b0 || inst_out !== 16'h0 || pc_out !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_out got v=%b inst=%h pc=%h exp 0/0000/0000", inst_valid, inst_out, pc_out);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    lat_lo = 1;
    lat_hi = 1;
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    n_tests++;
    if (imem_if.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_cycle_req got=%b exp=0", imem_if.imem_req);
    end
  endtask

  task automatic test_stream();
    bit          seen;
    int          gaps;
    logic [15:0] exp_addr;
    seen     = 1'b0;
    gaps     = 0;
    exp_addr = RESET_PC;
    lat_lo   = 1;
    lat_hi   = 1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      if (granted) begin
        n_tests++;
        if (granted_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL stream_addr got=%h exp=%h", granted_addr, exp_addr);
        end
        exp_addr = exp_addr + 16'd1;
      end
      if (seen && !inst_valid) gaps++;
      if (inst_valid) seen = 1'b1;
    end
    n_tests++;
    if (!seen || gaps != 0) begin
      n_fail++;
      $display("FAIL stream_continuity got seen=%b gaps=%0d exp seen=1 gaps=0", seen, gaps);
    end
  endtask

  task automatic test_stall_fill();
    logic [15:0] nxt;
    nxt = popped_pc + 16'd1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    n_tests++;
    if (imem_if.imem_req !== 1'b0 || inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_full got req=%b v=%b exp req=0 v=1", imem_if.imem_req, inst_valid);
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      if (k < 4) begin
        n_tests++;
        if (inst_valid !== 1'b1 || pc_out !== nxt + 16'(k)) begin
          n_fail++;
          $display("FAIL stall_drain k=%0d got v=%b pc=%h exp v=1 pc=%h", k, inst_valid, pc_out, nxt + 16'(k));
        end
      end else begin
        n_tests++;
        if (inst_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_drained got v=%b exp v=0", inst_valid);
        end
      end
    end
  endtask

  task automatic test_redirect_flush();
    bit ok;
    bit got_req;
    bit got_inst;
    int nresp;
    lat_lo = 3;
    lat_hi = 3;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      if (mem_q.size() == MAX_OUTST) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL flush_setup got outstanding=%0d exp=%0d", mem_q.size(), MAX_OUTST);
    end
    step(1'b0, 1'b1, 16'h0120, 1'b1, 1'b0);
    n_tests++;
    if (inst_valid !== 1'b0 || imem_if.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_cycle got v=%b req=%b exp 0/0", inst_valid, imem_if.imem_req);
    end
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    n_tests++;
    if (dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL flush_state got=%0d exp=2", dbg_state);
    end
    nresp   = imem_if.imem_rvalid ? 1 : 0;
    got_req = 1'b0;
    for (int i = 0; i < 20 && !got_req; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      if (imem_if.imem_rvalid) nresp++;
      if (granted) begin
        got_req = 1'b1;
        n_tests++;
        if (granted_addr !== 16'h0120) begin
          n_fail++;
          $display("FAIL flush_first_addr got=%h exp=0120", granted_addr);
        end
      end
    end
    n_tests++;
    if (!got_req || nresp != 2) begin
      n_fail++;
      $display("FAIL flush_dropped got req=%b drops=%0d exp req=1 drops=2", got_req, nresp);
    end
    got_inst = 1'b0;
    for (int i = 0; i < 20 && !got_inst; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      if (inst_valid) begin
        got_inst = 1'b1;
        n_tests++;
        if (pc_out !== 16'h0120 || inst_out !== inst_of(16'h0120)) begin
          n_fail++;
          $display("FAIL flush_first_pc got pc=%h inst=%h exp pc=0120 inst=%h", pc_out, inst_out, inst_of(16'h0120));
        end
      end
    end
    n_tests++;
    if (!got_inst) begin
      n_fail++;
      $display("FAIL flush_timeout got no instruction exp pc=0120");
    end
  endtask

  task automatic test_redirect_collide();
    bit ok;
    int nvalid;
    lat_lo = 1;
    lat_hi = 1;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      if (exp_q.size() > 0 && mem_q.size() > 0) begin
        if (mem_t[0] <= cyc) ok = 1'b1;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL collide_setup got no head+response pair exp one");
    end
    step(1'b0, 1'b1, 16'h0300, 1'b1, 1'b1);
    n_tests++;
    if (inst_valid !== 1'b0 || imem_if.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_cycle got v=%b req=%b exp 0/0", inst_valid, imem_if.imem_req);
    end
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    n_tests++;
    if (dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL collide_state got=%0d exp=1", dbg_state);
    end
    nvalid = 0;
    for (int i = 0; i < 20 && nvalid < 2; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      if (inst_valid) begin
        n_tests++;
        if (pc_out !== 16'h0300 + 16'(nvalid)) begin
          n_fail++;
          $display("FAIL collide_pc n=%0d got=%h exp=%h", nvalid, pc_out, 16'h0300 + 16'(nvalid));
        end
        nvalid++;
      end
    end
    n_tests++;
    if (nvalid != 2) begin
      n_fail++;
      $display("FAIL collide_timeout got=%0d exp=2", nvalid);
    end
  endtask

  task automatic test_wrap();
    int ng;
    int np;
    logic [15:0] want;
    lat_lo = 1;
    lat_hi = 1;
    step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    ng = 0;
    np = 0;
    for (int i = 0; i < 30 && (ng < 2 || np < 2); i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      if (granted && ng < 2) begin
        want = 16'hFFFF + 16'(ng);
        n_tests++;
        if (granted_addr !== want) begin
          n_fail++;
          $display("FAIL wrap_addr n=%0d got=%h exp=%h", ng, granted_addr, want);
        end
        ng++;
      end
      if (inst_valid && np < 2) begin
        want = 16'hFFFF + 16'(np);
        n_tests++;
        if (pc_out !== want) begin
          n_fail++;
          $display("FAIL wrap_pc n=%0d got=%h exp=%h", np, pc_out, want);
        end
        np++;
      end
    end
    n_tests++;
    if (ng != 2 || np != 2) begin
      n_fail++;
      $display("FAIL wrap_timeout got grants=%0d pcs=%0d exp 2/2", ng, np);
    end
  endtask

  task automatic test_reset_mid_flush();
    bit ok;
    int resp_cyc;
    int valid_cyc;
    int exp_delay;
    lat_lo = 4;
    lat_hi = 4;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      if (mem_q.size() == MAX_OUTST) ok = 1'b1;
    end
    step(1'b0, 1'b1, 16'h0200, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    n_tests++;
    if (!ok || dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL midflush_setup got ok=%b state=%0d exp ok=1 state=2", ok, dbg_state);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (imem_if.imem_req !== 1'b0 || imem_if.imem_addr !== RESET_PC || inst_valid !== 1'b0 ||
        inst_out !== 16'h0 || pc_out !== 16'h0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL midflush_reset got req=%b addr=%h v=%b inst=%h pc=%h st=%0d exp 0/%h/0/0000/0000/0",
               imem_if.imem_req, imem_if.imem_addr, inst_valid, inst_out, pc_out, dbg_state, RESET_PC);
    end
    drive_idle();
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    lat_lo = 1;
    lat_hi = 1;
    resp_cyc  = -1;
    valid_cyc = -1;
    for (int i = 0; i < 20 && valid_cyc < 0; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      if (imem_if.imem_rvalid && resp_cyc < 0) resp_cyc = i;
      if (inst_valid) begin
        valid_cyc = i;
        n_tests++;
        if (pc_out !== RESET_PC || inst_out !== inst_of(RESET_PC)) begin
          n_fail++;
          $display("FAIL restart_pc got pc=%h inst=%h exp pc=%h inst=%h", pc_out, inst_out, RESET_PC, inst_of(RESET_PC));
        end
      end
    end
`ifdef PREFETCH_BYPASS_EN
    exp_delay = 0;
`else
    exp_delay = 1;
`endif
    n_tests++;
    if (resp_cyc < 0 || valid_cyc - resp_cyc != exp_delay) begin
      n_fail++;
      $display("FAIL restart_latency got resp=%0d valid=%0d exp delay=%0d", resp_cyc, valid_cyc, exp_delay);
    end
  endtask

  task automatic test_random();
    int npop;
    bit st, rd, g, rok;
    npop   = 0;
    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(99, 0) < 30);
      rd  = ($urandom_range(99, 0) < 3);
      g   = ($urandom_range(99, 0) < 70);
      rok = ($urandom_range(99, 0) < 75);
      step(st, rd, 16'($urandom), g, rok);
      if (inst_valid && !st) npop++;
    end
    n_tests++;
    if (npop < 50) begin
      n_fail++;
      $display("FAIL random_throughput got pops=%0d exp>=50", npop);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    popped_pc    = 16'h0;
    granted_addr = 16'h0;
    test_reset();
    test_stream();
    test_stall_fill();
    test_redirect_flush();
    test_redirect_collide();
    test_wrap();
    test_reset_mid_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
